spi_time_tx: RTL and testbench

SPI_TIME_TX -- requirements
Module: spi_time_tx

---
 rtl/radclk_pkg.sv | 33 +++
 rtl/spi_time_tx_if.sv | 29 ++
 rtl/spi_time_tx_clkgen.sv | 43 ++++
 rtl/spi_time_tx.sv | 148 ++++++++++++++
 tb/tb_spi_time_tx.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/radclk_pkg.sv
// Constants and types shared by the time-frame SPI transmitter and its receiver.
// SPI_TIME_TX_PARITY_EN appends an even-parity bit to the frame.
package radclk_pkg;

  localparam int HOUR_W  = 5;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;
  localparam int MON_W   = 4;
  localparam int DAY_W   = 5;
  localparam int YEAR_W  = 6;
  localparam logic HEADER = 1'b1;
  localparam int FRAME_W = 33;

`ifdef SPI_TIME_TX_PARITY_EN
  localparam int FRAME_N = FRAME_W + 1;

  function automatic logic even_parity(input logic [FRAME_W-1:0] bits);
    return ^bits;
  endfunction
`else
  localparam int FRAME_N = FRAME_W;
`endif

  // Bit index must hold FRAME_N itself, hence the +1.
  localparam int CNT_W = $clog2(FRAME_N + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/spi_time_tx_if.sv
// Request/field/SPI bundle between a time source (master) and spi_time_tx (slave).
interface spi_time_tx_if
  import radclk_pkg::*;
();

  logic              start;
  logic [HOUR_W-1:0] hour;
  logic [MIN_W-1:0]  minute;
  logic [SEC_W-1:0]  second;
  logic [MON_W-1:0]  month;
  logic [DAY_W-1:0]  day;
  logic [YEAR_W-1:0] year;
  logic              sclk;
  logic              sdo;
  logic              cs_b;
  logic              busy;
  logic              done;

  modport master (
    output start, hour, minute, second, month, day, year,
    input  sclk, sdo, cs_b, busy, done
  );

  modport slave (
    input  start, hour, minute, second, month, day, year,
    output sclk, sdo, cs_b, busy, done
  );

endinterface

// File: rtl/spi_time_tx_clkgen.sv
// SPI clock generator: CLKDIV-cycle low and high phases while enabled,
// with strobes marking the last cycle of each phase.
module spi_clkgen #(
  parameter logic [9:0] CLKDIV = 10'd4
) (
  input  logic clk,
  input  logic reset_b,
  input  logic enable,
  output logic sclk,
  output logic low_end,
  output logic high_end
);

  logic [9:0] phase_cnt_r;
  logic       sclk_r;
  logic       phase_last_s;

  // Phase-end decode; strobes are only meaningful while enabled
  always_comb begin
    phase_last_s = (phase_cnt_r == (CLKDIV - 10'd1));
    low_end      = enable && phase_last_s && !sclk_r;
    high_end     = enable && phase_last_s && sclk_r;
  end

  // Phase counter and sclk; disabling parks sclk low at the start of a low phase
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      phase_cnt_r <= 10'd0;
      sclk_r      <= 1'b0;
    end else if (!enable) begin
      phase_cnt_r <= 10'd0;
      sclk_r      <= 1'b0;
    end else if (phase_last_s) begin
      phase_cnt_r <= 10'd0;
      sclk_r      <= ~sclk_r;
    end else begin
      phase_cnt_r <= phase_cnt_r + 10'd1;
    end
  end

  assign sclk = sclk_r;

endmodule

// File: rtl/spi_time_tx.sv
// Serialises a latched time/date snapshot as one SPI frame, MSB first.
// SPI_TIME_TX_PARITY_EN appends an even-parity bit as the last frame bit.
module spi_time_tx
  import radclk_pkg::*;
#(
  parameter logic [9:0] CLKDIV = 10'd4
) (
  input logic          clk,
  input logic          reset_b,
  spi_time_tx_if.slave bus
);

  state_t             state_r;
  state_t             state_next_s;
  logic [FRAME_N-1:0] frame_s;
  logic [FRAME_N-2:0] shift_r;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic               sdo_r;
  logic               cs_b_r;
  logic               busy_r;
  logic               done_r;
  logic               cs_b_next_s;
  logic               busy_next_s;
  logic               done_next_s;
  logic               sclk_s;
  logic               low_end_s;
  logic               high_end_s;
  logic               last_bit_s;

`ifdef SPI_TIME_TX_PARITY_EN
  logic [FRAME_W-1:0] body_s;
  assign body_s  = {HEADER, bus.hour, bus.minute, bus.second, bus.month, bus.day, bus.year};
  assign frame_s = {body_s, even_parity(body_s)};
`else
  assign frame_s = {HEADER, bus.hour, bus.minute, bus.second, bus.month, bus.day, bus.year};
`endif

  spi_clkgen #(
    .CLKDIV (CLKDIV)
  ) u_clkgen (
    .clk      (clk),
    .reset_b  (reset_b),
    .enable   (state_r == SHIFT),
    .sclk     (sclk_s),
    .low_end  (low_end_s),
    .high_end (high_end_s)
  );

  // The index drops mid-bit, so it already reads zero during the last high phase
  assign last_bit_s = (bit_cnt_r == CNT_W'(0));

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_next_s = SHIFT;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (high_end_s && last_bit_s) begin
          state_next_s = FINISH;
        end else begin
          state_next_s = SHIFT;
        end
      end
      FINISH:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the outputs can be registered
  always_comb begin
    cs_b_next_s = 1'b1;
    busy_next_s = 1'b0;
    done_next_s = 1'b0;
    case (state_next_s)
      SHIFT: begin
        cs_b_next_s = 1'b0;
        busy_next_s = 1'b1;
      end
      FINISH:  done_next_s = 1'b1;
      default: done_next_s = 1'b0;
    endcase
  end

  // State register and registered control outputs
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_r <= IDLE;
      cs_b_r  <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cs_b_r  <= cs_b_next_s;
      busy_r  <= busy_next_s;
      done_r  <= done_next_s;
    end
  end

  // Shift register, serial data and bit index; sdo only moves at the start of a low phase
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      shift_r   <= '0;
      sdo_r     <= 1'b0;
      bit_cnt_r <= CNT_W'(0);
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            sdo_r     <= frame_s[FRAME_N-1];
            shift_r   <= frame_s[FRAME_N-2:0];
            bit_cnt_r <= CNT_W'(FRAME_N);
          end else begin
            sdo_r <= 1'b0;
          end
        end
        SHIFT: begin
          if (low_end_s) begin
            bit_cnt_r <= bit_cnt_r - CNT_W'(1);
          end else if (high_end_s) begin
            if (last_bit_s) begin
              sdo_r <= 1'b0;
            end else begin
              sdo_r   <= shift_r[FRAME_N-2];
              shift_r <= {shift_r[FRAME_N-3:0], 1'b0};
            end
          end else begin
            sdo_r <= sdo_r;
          end
        end
        FINISH:  sdo_r <= 1'b0;
        default: sdo_r <= 1'b0;
      endcase
    end
  end

  assign bus.sclk = sclk_s;
  assign bus.sdo  = sdo_r;
  assign bus.cs_b = cs_b_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_spi_time_tx.sv
// Randomised self-checking bench for spi_time_tx: a CLKDIV=4 and a CLKDIV=2 instance,
// an SPI bus monitor per instance, and an arithmetic frame model.
module tb_spi_time_tx;

  logic clk;
  logic reset_b;
  longint n_checks;
  longint n_fail;

`ifdef SPI_TIME_TX_PARITY_EN
  localparam longint N_BITS = 64'd34;
`else
  localparam longint N_BITS = 64'd33;
`endif
  localparam logic [63:0] GOLD33 = 64'b1_01101_101101_011110_1011_10001_001110;

  spi_time_tx_if bus_a ();
  spi_time_tx_if bus_b ();

  spi_time_tx #(.CLKDIV(10'd4)) dut_a (.clk(clk), .reset_b(reset_b), .bus(bus_a));
  spi_time_tx #(.CLKDIV(10'd2)) dut_b (.clk(clk), .reset_b(reset_b), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] sclk_v, sdo_v, cs_v, busy_v, done_v;
  assign sclk_v = {bus_b.sclk, bus_a.sclk};
  assign sdo_v  = {bus_b.sdo,  bus_a.sdo};
  assign cs_v   = {bus_b.cs_b, bus_a.cs_b};
  assign busy_v = {bus_b.busy, bus_a.busy};
  assign done_v = {bus_b.done, bus_a.done};

  function automatic longint div_of(input int i);
    return (i == 0) ? 64'd4 : 64'd2;
  endfunction

  // Frame as a number: each field appended by multiplying by 2^width.
  function automatic logic [63:0] model_frame(input longint h, m, s, mo, d, y);
    logic [63:0] v;
    int ones;
    v = 64'd1;
    v = v * 64'd32 + h;
    v = v * 64'd64 + m;
    v = v * 64'd64 + s;
    v = v * 64'd16 + mo;
    v = v * 64'd32 + d;
    v = v * 64'd64 + y;
    ones = 0;
    for (int k = 0; k < 33; k++) ones += int'(v[k]);
`ifdef SPI_TIME_TX_PARITY_EN
    v = v * 64'd2 + 64'(ones % 2);
`endif
    return v;
  endfunction

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor state (index 0 = dut_a, 1 = dut_b)
  logic [1:0]  prev_sclk, prev_sdo, prev_cs;
  logic [63:0] rx_acc [2];
  logic [63:0] last_bits [2];
  longint rx_n [2], phase_run [2], cs_low_run [2];
  longint last_len [2], last_cs_low [2];
  longint frames_start [2], frames_end [2], done_total [2];
  longint phase_bad [2], glitch [2], busy_bad [2], done_bad [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      prev_sclk[i] <= sclk_v[i];
      prev_sdo[i]  <= sdo_v[i];
      prev_cs[i]   <= cs_v[i];
      if (!reset_b) begin
        phase_run[i]  <= 64'd0;
        cs_low_run[i] <= 64'd0;
        rx_n[i]       <= 64'd0;
      end else begin
        if (busy_v[i] == cs_v[i]) busy_bad[i] <= busy_bad[i] + 64'd1;
        if (done_v[i]) begin
          done_total[i] <= done_total[i] + 64'd1;
          if (!(cs_v[i] && !prev_cs[i] && !sclk_v[i] && !sdo_v[i])) done_bad[i] <= done_bad[i] + 64'd1;
        end
        if (!cs_v[i]) begin
          if (prev_cs[i]) begin
            frames_start[i] <= frames_start[i] + 64'd1;
            cs_low_run[i]   <= 64'd1;
            phase_run[i]    <= 64'd1;
            rx_n[i]         <= 64'd0;
            rx_acc[i]       <= 64'd0;
            if (sclk_v[i]) phase_bad[i] <= phase_bad[i] + 64'd1;
          end else begin
            cs_low_run[i] <= cs_low_run[i] + 64'd1;
            if (sclk_v[i] != prev_sclk[i]) begin
              if (phase_run[i] != div_of(i)) phase_bad[i] <= phase_bad[i] + 64'd1;
              phase_run[i] <= 64'd1;
            end else begin
              phase_run[i] <= phase_run[i] + 64'd1;
            end
            if ((sdo_v[i] != prev_sdo[i]) && !(prev_sclk[i] && !sclk_v[i])) glitch[i] <= glitch[i] + 64'd1;
            if (sclk_v[i] && !prev_sclk[i]) begin
              rx_acc[i] <= {rx_acc[i][62:0], sdo_v[i]};
              rx_n[i]   <= rx_n[i] + 64'd1;
            end
          end
        end else if (!prev_cs[i]) begin
          if ((phase_run[i] != div_of(i)) || !prev_sclk[i]) phase_bad[i] <= phase_bad[i] + 64'd1;
          last_bits[i]   <= rx_acc[i];
          last_len[i]    <= rx_n[i];
          last_cs_low[i] <= cs_low_run[i];
          frames_end[i]  <= frames_end[i] + 64'd1;
        end else if (sclk_v[i]) begin
          phase_bad[i] <= phase_bad[i] + 64'd1;
        end
      end
    end
  end

  task automatic set_in(input int i, input logic st, input longint h, m, s, mo, d, y);
    if (i == 0) begin
      bus_a.start = st; bus_a.hour = 5'(h); bus_a.minute = 6'(m); bus_a.second = 6'(s);
      bus_a.month = 4'(mo); bus_a.day = 5'(d); bus_a.year = 6'(y);
    end else begin
      bus_b.start = st; bus_b.hour = 5'(h); bus_b.minute = 6'(m); bus_b.second = 6'(s);
      bus_b.month = 4'(mo); bus_b.day = 5'(d); bus_b.year = 6'(y);
    end
  endtask

  task automatic scramble(input int i, input logic st);
    set_in(i, st, 64'($urandom_range(31, 0)), 64'($urandom_range(63, 0)), 64'($urandom_range(63, 0)),
           64'($urandom_range(15, 0)), 64'($urandom_range(31, 0)), 64'($urandom_range(63, 0)));
  endtask

  // One-cycle start; fields are changed right after acceptance.
  task automatic send(input int i, input longint h, m, s, mo, d, y);
    @(posedge clk); #1;
    set_in(i, 1'b1, h, m, s, mo, d, y);
    @(posedge clk); #1;
    scramble(i, 1'b0);
  endtask

  task automatic wait_bits(input int i, input longint k);
    for (int c = 0; c < 400 && rx_n[i] < k; c++) begin
      @(posedge clk); #1;
    end
    check("bit_wait", longint'(rx_n[i] >= k), 64'd1);
  endtask

  task automatic wait_end(input int i, input longint base);
    for (int c = 0; c < 400 && frames_end[i] == base; c++) begin
      @(posedge clk); #1;
    end
    check("frame_end", frames_end[i] - base, 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic frame_check(input int i, input longint h, m, s, mo, d, y);
    logic [63:0] exp;
    longint fs0, fe0, dn0;
    exp = model_frame(h, m, s, mo, d, y);
    fs0 = frames_start[i]; fe0 = frames_end[i]; dn0 = done_total[i];
    send(i, h, m, s, mo, d, y);
    wait_end(i, fe0);
    check("frame_bits", last_bits[i], exp);
    check("rise_count", last_len[i], N_BITS);
    check("cs_low_cycles", last_cs_low[i], 64'd2 * div_of(i) * N_BITS);
    check("frame_count", frames_start[i] - fs0, 64'd1);
    check("done_count", done_total[i] - dn0, 64'd1);
  endtask

  initial begin
    longint r [6];
    logic [63:0] exp;
    longint fs0, fe0, dn0;
    n_checks = 0;
    n_fail = 0;
    reset_b = 1'b0;
    set_in(0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd1, 64'd1, 64'd0);
    set_in(1, 1'b0, 64'd0, 64'd0, 64'd0, 64'd1, 64'd1, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_b", 64'(bus_a.cs_b), 64'd1);
    check("rst_sclk", 64'(bus_a.sclk), 64'd0);
    check("rst_sdo", 64'(bus_a.sdo), 64'd0);
    check("rst_busy", 64'(bus_a.busy), 64'd0);
    check("rst_done", 64'(bus_a.done), 64'd0);
    check("rst_b_cs_b", 64'(bus_b.cs_b), 64'd1);
    reset_b = 1'b1;
    repeat (2) @(posedge clk);

    // Reference fields, checked against the literal bit pattern as well
    frame_check(0, 64'd13, 64'd45, 64'd30, 64'd11, 64'd17, 64'd14);
`ifdef SPI_TIME_TX_PARITY_EN
    exp = {GOLD33[62:0], ^GOLD33};
`else
    exp = GOLD33;
`endif
    check("golden_bits", last_bits[0], exp);

    // Random fields over the full port widths (no clamping expected)
    for (int t = 0; t < 3; t++) begin
      foreach (r[k]) r[k] = 64'($urandom_range(63, 0));
      frame_check(0, r[0] % 64'd32, r[1], r[2], r[3] % 64'd16, r[4] % 64'd32, r[5]);
    end

    // Second start mid-frame is ignored
    exp = model_frame(64'd7, 64'd3, 64'd59, 64'd2, 64'd28, 64'd41);
    fs0 = frames_start[0]; fe0 = frames_end[0]; dn0 = done_total[0];
    send(0, 64'd7, 64'd3, 64'd59, 64'd2, 64'd28, 64'd41);
    wait_bits(0, 64'd10);
    send(0, 64'd22, 64'd58, 64'd1, 64'd9, 64'd3, 64'd60);
    wait_end(0, fe0);
    repeat (40) @(posedge clk);
    #1;
    check("midstart_bits", last_bits[0], exp);
    check("midstart_frames", frames_start[0] - fs0, 64'd1);
    check("midstart_done", done_total[0] - dn0, 64'd1);

    // Start during the FINISH cycle is ignored
    exp = model_frame(64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6);
    fs0 = frames_start[0]; dn0 = done_total[0];
    send(0, 64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6);
    for (int c = 0; c < 400 && bus_a.done !== 1'b1; c++) begin
      @(posedge clk); #1;
    end
    check("finish_seen", 64'(bus_a.done), 64'd1);
    set_in(0, 1'b1, 64'd31, 64'd63, 64'd63, 64'd15, 64'd31, 64'd63);
    @(posedge clk); #1;
    scramble(0, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    check("finish_start_frames", frames_start[0] - fs0, 64'd1);
    check("finish_start_bits", last_bits[0], exp);
    check("finish_start_done", done_total[0] - dn0, 64'd1);

    // Asynchronous reset at bit 20 aborts without done
    dn0 = done_total[0];
    send(0, 64'd20, 64'd20, 64'd20, 64'd10, 64'd20, 64'd20);
    wait_bits(0, 64'd20);
    reset_b = 1'b0;
    #1;
    check("abort_cs_b", 64'(bus_a.cs_b), 64'd1);
    check("abort_sclk", 64'(bus_a.sclk), 64'd0);
    check("abort_sdo", 64'(bus_a.sdo), 64'd0);
    check("abort_busy", 64'(bus_a.busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", done_total[0] - dn0, 64'd0);
    foreach (r[k]) r[k] = 64'($urandom_range(63, 0));
    frame_check(0, r[0] % 64'd32, r[1], r[2], r[3] % 64'd16, r[4] % 64'd32, r[5]);

    // CLKDIV=2 instance: maximal fields, then a random frame
    frame_check(1, 64'd23, 64'd59, 64'd59, 64'd12, 64'd31, 64'd63);
    foreach (r[k]) r[k] = 64'($urandom_range(63, 0));
    frame_check(1, r[0] % 64'd32, r[1], r[2], r[3] % 64'd16, r[4] % 64'd32, r[5]);

    for (int i = 0; i < 2; i++) begin
      check("phase_len_errors", phase_bad[i], 64'd0);
      check("sdo_change_errors", glitch[i], 64'd0);
      check("busy_errors", busy_bad[i], 64'd0);
      check("done_shape_errors", done_bad[i], 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
